mem_block_mover: RTL and testbench

Initiator-side engine for the unified 16-bit word memory. It is the requester that drives Address/DataIn/MemWrite and consumes MemVal. It accepts one command at a time over a valid/ready handshake: single read, single write, block copy or block fill. It sequences the memory's registered-read timing and returns one response per command. It sits between the datapath or debug/loader logic and the memory port, and owns that port while busy.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_range_check.sv | 25 ++
 rtl/mem_block_mover.sv | 138 +++++++++++++
 tb/tb_mem_block_mover.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and sizes for the block mover
package mem_pkg;

  localparam int MEM_TOP = 256;
  localparam int AW      = 16;
  localparam int DW      = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_range_check.sv
// rtl/mem_range_check.sv - flags a command whose touched word range leaves the memory
module mem_range_check
  import mem_pkg::*;
#(
  parameter bit IS_SRC = 1'b0
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  op_t           op,
  output logic          err
);

  logic          used;
  logic [AW:0]   eff_len;
  logic [AW:0]   end_excl;

  // One extra bit so base+len cannot wrap; the range is legal while base+len <= MEM_TOP+1.
  always_comb begin
    used     = IS_SRC ? (op == OP_READ || op == OP_COPY) : (op != OP_READ);
    eff_len  = (op == OP_READ || op == OP_WRITE) ? (AW+1)'(1) : {1'b0, len};
    end_excl = {1'b0, base} + eff_len;
    err      = used && (eff_len != '0) && (end_excl > (AW+1)'(MEM_TOP + 1));
  end

endmodule

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - single-command read/write/copy/fill engine on the word memory port
module mem_block_mover
  import mem_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] DataIn,
  output logic          MemWrite,
  input  logic [DW-1:0] MemVal
);

  state_t        state, state_nx;
  op_t           op_reg;
  logic [AW-1:0] src_reg, dst_reg, cnt_reg;
  logic [DW-1:0] data_reg;
  logic          err_reg;

  op_t           op_in;
  logic          accept;
  logic          src_err, dst_err, range_err;
  logic [AW-1:0] len_eff;

  assign op_in     = op_t'(cmd_op);
  assign accept    = cmd_valid && (state == IDLE);
  assign range_err = src_err || dst_err;
  assign len_eff   = (op_in == OP_READ || op_in == OP_WRITE) ? AW'(1) : cmd_len;

  mem_range_check #(.IS_SRC(1'b1)) u_src_check (
    .base (cmd_src),
    .len  (cmd_len),
    .op   (op_in),
    .err  (src_err)
  );

  mem_range_check #(.IS_SRC(1'b0)) u_dst_check (
    .base (cmd_dst),
    .len  (cmd_len),
    .op   (op_in),
    .err  (dst_err)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and memory-port / handshake outputs.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    Address   = '0;
    DataIn    = '0;
    MemWrite  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          if (range_err || len_eff == '0)                state_nx = RESP;
          else if (op_in == OP_READ || op_in == OP_COPY) state_nx = RD;
          else                                           state_nx = WR;
        end
      end
      RD: begin
        Address  = src_reg;
        state_nx = RDW;
      end
      RDW: begin
        Address  = src_reg;
        state_nx = (op_reg == OP_READ) ? RESP : WR;
      end
      WR: begin
        Address  = dst_reg;
        DataIn   = data_reg;
        MemWrite = 1'b1;
        if (cnt_reg == AW'(1))       state_nx = RESP;
        else if (op_reg == OP_COPY)  state_nx = RD;
        else                         state_nx = WR;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only READ and COPY return a data word; data_reg is zeroed at accept for them.
  assign rsp_data = (rsp_valid && (op_reg == OP_READ || op_reg == OP_COPY)) ? data_reg : '0;
  assign rsp_err  = rsp_valid && err_reg;

  // Command latch, read capture and per-word address/count stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg   <= OP_READ;
      src_reg  <= '0;
      dst_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_reg   <= op_in;
          src_reg  <= cmd_src;
          dst_reg  <= cmd_dst;
          cnt_reg  <= len_eff;
          data_reg <= (op_in == OP_WRITE || op_in == OP_FILL) ? cmd_data : '0;
          err_reg  <= range_err;
        end
        RDW: data_reg <= MemVal;
        WR: begin
          src_reg <= src_reg + AW'(1);
          dst_reg <= dst_reg + AW'(1);
          cnt_reg <= cnt_reg - AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - self-checking bench for mem_block_mover with a word memory model
module tb_mem_block_mover;
  import mem_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst, cmd_len;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] Address;
  logic [DW-1:0] DataIn;
  logic          MemWrite;
  logic [DW-1:0] MemVal;

  always #5 clock = ~clock;

  mem_block_mover dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .Address(Address), .DataIn(DataIn), .MemWrite(MemWrite), .MemVal(MemVal)
  );

  logic [DW-1:0] mem     [0:MEM_TOP];
  logic [DW-1:0] ref_mem [0:MEM_TOP];
  int            wr_total = 0;
  int            n_tests  = 0;
  int            n_fail   = 0;

  function automatic logic [15:0] img(int i);
    case (i)
      0:       img = 16'h0008;
      1:       img = 16'h0814;
      2:       img = 16'h8014;
      default: img = 16'(i * 37) ^ 16'hA5C3;
    endcase
  endfunction

  // Memory with registered read; reset reloads the image.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= MEM_TOP; i++) mem[i] <= img(i);
      MemVal <= '0;
    end else begin
      if (MemWrite && Address <= 16'(MEM_TOP)) mem[Address] <= DataIn;
      MemVal <= (Address <= 16'(MEM_TOP)) ? mem[Address] : '0;
    end
  end

  // Counts write strobes seen by the memory.
  always @(posedge clock) begin
    if (!reset && MemWrite) wr_total <= wr_total + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i <= MEM_TOP; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Reference: acts on whole word ranges, derived from the command rules.
  task automatic model_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                           input logic [15:0] data, output logic [15:0] e_data,
                           output logic e_err, output int e_lat, output int e_wr);
    int n;
    bit uses_src, uses_dst;
    n        = (op == OP_READ || op == OP_WRITE) ? 1 : len;
    uses_src = (op == OP_READ || op == OP_COPY);
    uses_dst = (op != OP_READ);
    e_data = '0; e_err = 1'b0; e_lat = 1; e_wr = 0;
    if (n > 0 && ((uses_src && src + n - 1 > MEM_TOP) || (uses_dst && dst + n - 1 > MEM_TOP))) begin
      e_err = 1'b1;
    end else if (n > 0) begin
      case (op)
        OP_READ:  begin e_data = ref_mem[src]; e_lat = 3; end
        OP_WRITE: begin ref_mem[dst] = data; e_lat = 2; e_wr = 1; end
        OP_COPY: begin
          for (int i = 0; i < n; i++) ref_mem[dst + i] = ref_mem[src + i];
          e_data = ref_mem[dst + n - 1]; e_lat = 3 * n + 1; e_wr = n;
        end
        default: begin
          for (int i = 0; i < n; i++) ref_mem[dst + i] = data;
          e_lat = n + 1; e_wr = n;
        end
      endcase
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [15:0] data, input int hold,
                         output logic [15:0] g_data, output logic g_err, output int g_lat,
                         output int g_wr);
    int w0;
    bit bad;
    @(negedge clock);
    check("ready before cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
    w0 = wr_total;
    @(posedge clock);
    g_lat = 1;
    @(negedge clock);
    // Offer a stray write while busy; it must not be taken.
    cmd_valid = 1'($urandom_range(0, 1)); cmd_op = OP_WRITE; cmd_dst = 16'd5; cmd_data = 16'hDEAD;
    while (!rsp_valid && g_lat < 2000) begin
      @(posedge clock); g_lat++; @(negedge clock);
    end
    check("response timeout", rsp_valid, 1'b1);
    g_data = rsp_data; g_err = rsp_err; g_wr = wr_total - w0;
    bad = 1'b0;
    repeat (hold) begin
      @(posedge clock); @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== g_data || rsp_err !== g_err || cmd_ready !== 1'b0)
        bad = 1'b1;
    end
    if (hold > 0) check("rsp held stable", bad, 1'b0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    rsp_ready = 1'b0;
    check("idle after rsp", {rsp_valid, cmd_ready, busy, MemWrite}, 4'b0100);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] src, dst, len, data;
    int          hold;
    logic [15:0] e_data;
    logic        e_err;
    int          e_lat, e_wr;
  } vec_t;

  vec_t        tbl [15];
  logic [15:0] g_data, m_data;
  logic        g_err, m_err;
  int          g_lat, g_wr, m_lat, m_wr, w0, guard;

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i <= MEM_TOP; i++) ref_mem[i] = img(i);
  endtask

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0; cmd_data = 0; rsp_ready = 0;
    tbl[0]  = '{OP_READ,  16'd1,   16'd0,    16'd0,  16'h0000, 0, 16'h0814, 1'b0, 3,  0};
    tbl[1]  = '{OP_WRITE, 16'd0,   16'd200,  16'd0,  16'h1234, 0, 16'h0000, 1'b0, 2,  1};
    tbl[2]  = '{OP_READ,  16'd200, 16'd0,    16'd0,  16'h0000, 0, 16'h1234, 1'b0, 3,  0};
    tbl[3]  = '{OP_COPY,  16'd0,   16'd150,  16'd3,  16'h0000, 0, 16'h8014, 1'b0, 10, 3};
    tbl[4]  = '{OP_READ,  16'd152, 16'd0,    16'd0,  16'h0000, 0, 16'h8014, 1'b0, 3,  0};
    tbl[5]  = '{OP_FILL,  16'd0,   16'd240,  16'd17, 16'hBEEF, 0, 16'h0000, 1'b0, 18, 17};
    tbl[6]  = '{OP_READ,  16'd256, 16'd0,    16'd0,  16'h0000, 0, 16'hBEEF, 1'b0, 3,  0};
    tbl[7]  = '{OP_FILL,  16'd0,   16'd241,  16'd17, 16'hBEEF, 0, 16'h0000, 1'b1, 1,  0};
    tbl[8]  = '{OP_COPY,  16'd255, 16'd10,   16'd3,  16'h0000, 0, 16'h0000, 1'b1, 1,  0};
    tbl[9]  = '{OP_COPY,  16'd5,   16'd20,   16'd0,  16'h0000, 5, 16'h0000, 1'b0, 1,  0};
    tbl[10] = '{OP_READ,  16'd257, 16'd0,    16'd0,  16'h0000, 0, 16'h0000, 1'b1, 1,  0};
    tbl[11] = '{OP_FILL,  16'd0,   16'hFFFF, 16'd2,  16'h5555, 0, 16'h0000, 1'b1, 1,  0};
    tbl[12] = '{OP_WRITE, 16'd0,   16'd256,  16'd9,  16'h7777, 0, 16'h0000, 1'b0, 2,  1};
    tbl[13] = '{OP_COPY,  16'd150, 16'd151,  16'd2,  16'h0000, 0, 16'h0008, 1'b0, 7,  2};
    tbl[14] = '{OP_READ,  16'd1,   16'd0,    16'd0,  16'h0000, 3, 16'h0814, 1'b0, 3,  0};

    do_reset();
    check("reset outputs",
          {cmd_ready, rsp_valid, busy, MemWrite, rsp_err, Address, DataIn, rsp_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0});

    for (int k = 0; k < 15; k++) begin
      run_cmd(tbl[k].op, tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].data, tbl[k].hold,
              g_data, g_err, g_lat, g_wr);
      model_cmd(tbl[k].op, tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].data,
                m_data, m_err, m_lat, m_wr);
      check($sformatf("vec%0d data", k), g_data, tbl[k].e_data);
      check($sformatf("vec%0d err", k), g_err, tbl[k].e_err);
      check($sformatf("vec%0d latency", k), g_lat, tbl[k].e_lat);
      check($sformatf("vec%0d writes", k), g_wr, tbl[k].e_wr);
      check_mem($sformatf("vec%0d mem", k));
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [15:0] s, d, l, v;
      op = 2'($urandom_range(0, 3));
      s  = 16'($urandom_range(0, 262));
      d  = 16'($urandom_range(0, 262));
      l  = 16'($urandom_range(0, 9));
      v  = 16'($urandom);
      run_cmd(op, s, d, l, v, $urandom_range(0, 2), g_data, g_err, g_lat, g_wr);
      model_cmd(op, s, d, l, v, m_data, m_err, m_lat, m_wr);
      check($sformatf("rnd%0d op%0d data", k, op), g_data, m_data);
      check($sformatf("rnd%0d op%0d err", k, op), g_err, m_err);
      check($sformatf("rnd%0d op%0d latency", k, op), g_lat, m_lat);
      check($sformatf("rnd%0d op%0d writes", k, op), g_wr, m_wr);
      check_mem($sformatf("rnd%0d mem", k));
    end

    // Reset in the middle of a COPY, right after its second write.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = OP_COPY; cmd_src = 16'd0; cmd_dst = 16'd100; cmd_len = 16'd5;
    w0 = wr_total;
    @(posedge clock); @(negedge clock);
    cmd_valid = 1'b0;
    guard = 0;
    while (wr_total - w0 < 2 && guard < 100) begin
      @(posedge clock); @(negedge clock); guard++;
    end
    check("midcopy two writes", wr_total - w0, 2);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("midcopy reset idle", {busy, MemWrite, rsp_valid, cmd_ready}, 4'b0001);
    reset = 1'b0;
    for (int i = 0; i <= MEM_TOP; i++) ref_mem[i] = img(i);
    guard = 0;
    repeat (12) begin
      @(posedge clock); @(negedge clock);
      if (rsp_valid || MemWrite || busy) guard++;
    end
    check("midcopy stays quiet", guard, 0);
    check_mem("midcopy mem reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
